vga_timing_gen: RTL and testbench

- VGA raster timing generator and pixel output stage; default mode is 640x480 @ 60 Hz with a 25.175/25 MHz pixel clock.
- Drives pixel coordinates (o_x, o_y) to the upstream frame/renderer logic.
- Accepts that pixel's 4-bit RGB back on the following cycle.
- Emits registered, blank-gated RGB plus HS/VS to the board VGA connector.

---
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with blank-gated RGB and HS/VS output stage.
// Optional build macro VGA_TEST_PATTERN_EN replaces i_r/g/b with an internal 8-bar colour pattern.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk_vga,
    input  logic        rst_vga_n,
    input  logic [3:0]  i_r,
    input  logic [3:0]  i_g,
    input  logic [3:0]  i_b,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
    output logic        o_vga_vs,
    output logic        o_vga_hs,
    output logic [3:0]  o_vga_r,
    output logic [3:0]  o_vga_g,
    output logic [3:0]  o_vga_b
);

    localparam int   H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   H_SYNC_START = H_ACTIVE + H_FP;
    localparam int   H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int   V_SYNC_START = V_ACTIVE + V_FP;
    localparam int   V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam logic SYNC_ON      = (SYNC_POL != 0);

    logic [10:0] h_cnt_reg, h_cnt_next;
    logic [10:0] v_cnt_reg, v_cnt_next;
    logic        h_wrap;
    logic        active;
    logic        h_sync;
    logic        v_sync;
    logic        active_d1_reg;
    logic        hs_reg;
    logic        vs_reg;
    logic [3:0]  src_rgb [3];
    logic [3:0]  out_rgb [3];

    always_comb begin
        h_wrap     = (h_cnt_reg == 11'(H_TOTAL - 1));
        h_cnt_next = h_wrap ? 11'd0 : h_cnt_reg + 11'd1;
        v_cnt_next = v_cnt_reg;
        if (h_wrap) begin
            v_cnt_next = (v_cnt_reg == 11'(V_TOTAL - 1)) ? 11'd0 : v_cnt_reg + 11'd1;
        end
    end

    assign active = (h_cnt_reg < 11'(H_ACTIVE)) && (v_cnt_reg < 11'(V_ACTIVE));
    assign h_sync = (h_cnt_reg >= 11'(H_SYNC_START)) && (h_cnt_reg < 11'(H_SYNC_END));
    assign v_sync = (v_cnt_reg >= 11'(V_SYNC_START)) && (v_cnt_reg < 11'(V_SYNC_END));

    // Coordinates are forced to zero in blanking so upstream address logic stays in range.
    assign o_x = active ? h_cnt_reg : 11'd0;
    assign o_y = active ? v_cnt_reg : 11'd0;

    always_ff @(posedge clk_vga or negedge rst_vga_n) begin
        if (!rst_vga_n) begin
            h_cnt_reg     <= 11'd0;
            v_cnt_reg     <= 11'd0;
            active_d1_reg <= 1'b0;
            hs_reg        <= ~SYNC_ON;
            vs_reg        <= ~SYNC_ON;
        end else begin
            h_cnt_reg     <= h_cnt_next;
            v_cnt_reg     <= v_cnt_next;
            active_d1_reg <= active;
            hs_reg        <= h_sync ? SYNC_ON : ~SYNC_ON;
            vs_reg        <= v_sync ? SYNC_ON : ~SYNC_ON;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Bar colours decode directly from the bar index bits: R=~b1, G=~b2, B=~b0.
    logic [2:0]  bar_idx;
    logic [11:0] pat_reg;

    assign bar_idx = o_x[9:7];

    always_ff @(posedge clk_vga or negedge rst_vga_n) begin
        if (!rst_vga_n) begin
            pat_reg <= 12'h000;
        end else begin
            pat_reg <= {{4{~bar_idx[1]}}, {4{~bar_idx[2]}}, {4{~bar_idx[0]}}};
        end
    end

    assign src_rgb[0] = pat_reg[11:8];
    assign src_rgb[1] = pat_reg[7:4];
    assign src_rgb[2] = pat_reg[3:0];
`else
    assign src_rgb[0] = i_r;
    assign src_rgb[1] = i_g;
    assign src_rgb[2] = i_b;
`endif

    // Colour arrives one cycle after its coordinate, so gating with active_d1 keeps it aligned with HS/VS.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_blank
            assign out_rgb[gi] = active_d1_reg ? src_rgb[gi] : 4'h0;
        end
    endgenerate

    assign o_vga_r  = out_rgb[0];
    assign o_vga_g  = out_rgb[1];
    assign o_vga_b  = out_rgb[2];
    assign o_vga_hs = hs_reg;
    assign o_vga_vs = vs_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny-mode, active-high-sync instance for frame wrap.
module tb_vga_timing_gen;

    localparam int SHA = 20, SHF = 3, SHS = 5, SHB = 4;
    localparam int SVA = 6,  SVF = 2, SVS = 2, SVB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  i_r = 4'hF, i_g = 4'hF, i_b = 4'hF;
    logic [10:0] d_x, d_y, s_x, s_y;
    logic        d_hs, d_vs, s_hs, s_vs;
    logic [3:0]  d_r, d_g, d_b, s_r, s_g, s_b;

    int checks = 0;
    int errors = 0;
    int t = 0;
    bit align = 1'b0;
    bit phase_b = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk_vga(clk), .rst_vga_n(rst_n), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_x(d_x), .o_y(d_y), .o_vga_vs(d_vs), .o_vga_hs(d_hs),
        .o_vga_r(d_r), .o_vga_g(d_g), .o_vga_b(d_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1)
    ) dut_s (
        .clk_vga(clk), .rst_vga_n(rst_n), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_x(s_x), .o_y(s_y), .o_vga_vs(s_vs), .o_vga_hs(s_hs),
        .o_vga_r(s_r), .o_vga_g(s_g), .o_vga_b(s_b)
    );

    typedef struct {
        int x;
        int y;
        int hs;
        int vs;
        int rgb;
    } exp_t;

    typedef struct {
        int t;
        int x;
        int y;
        int hs;
        int vs;
    } vec_t;

    function automatic int bar_colour(int x);
        int lut [8];
        lut = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        return lut[(x / 128) % 8];
    endfunction

    // n = rising edges since reset release; the raster position is simply n modulo the line/frame size.
    function automatic exp_t model(int n, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb, int pol, int in_rgb);
        exp_t m;
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        int h  = n % ht;
        int v  = (n / ht) % vt;
        int hp, vp;
        bit act;
        m.x = (h < ha && v < va) ? h : 0;
        m.y = (h < ha && v < va) ? v : 0;
        if (n == 0) begin
            m.hs  = (pol != 0) ? 0 : 1;
            m.vs  = (pol != 0) ? 0 : 1;
            m.rgb = 0;
        end else begin
            hp  = (n - 1) % ht;
            vp  = ((n - 1) / ht) % vt;
            act = (hp < ha) && (vp < va);
            m.hs = (hp >= ha + hf && hp < ha + hf + hsw) ? pol : 1 - pol;
            m.vs = (vp >= va + vf && vp < va + vf + vsw) ? pol : 1 - pol;
`ifdef VGA_TEST_PATTERN_EN
            m.rgb = act ? bar_colour(hp) : 0;
`else
            m.rgb = act ? in_rgb : 0;
`endif
        end
        return m;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    task automatic compare_all();
        exp_t e;
        int in_rgb = {i_r, i_g, i_b};
        e = model(t, 640, 16, 96, 48, 480, 10, 2, 33, 0, in_rgb);
        check("d_x", d_x, e.x);
        check("d_y", d_y, e.y);
        check("d_sync", {d_hs, d_vs}, {e.hs[0], e.vs[0]});
        check("d_rgb", {d_r, d_g, d_b}, e.rgb);
        e = model(t, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1, in_rgb);
        check("s_xy", {s_x, s_y}, {e.x[10:0], e.y[10:0]});
        check("s_sync", {s_hs, s_vs}, {e.hs[0], e.vs[0]});
        check("s_rgb", {s_r, s_g, s_b}, e.rgb);
    endtask

    task automatic step();
        logic [10:0] prev_x;
        logic [11:0] rnd;
        prev_x = d_x;
        @(posedge clk);
        #1;
        t++;
        rnd = 12'($urandom_range(0, 4095));
        {i_r, i_g, i_b} = rnd;
        if (align) begin
            i_r = prev_x[3:0];
        end else if (phase_b && t >= 801 && t <= 1600) begin
            {i_r, i_g, i_b} = 12'hFFF;
        end
        #1;
        compare_all();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_d_xy"}, {d_x, d_y}, 0);
        check({tag, "_d_sync"}, {d_hs, d_vs}, 2'b11);
        check({tag, "_d_rgb"}, {d_r, d_g, d_b}, 0);
        check({tag, "_s_xy"}, {s_x, s_y}, 0);
        check({tag, "_s_sync"}, {s_hs, s_vs}, 2'b00);
        check({tag, "_s_rgb"}, {s_r, s_g, s_b}, 0);
    endtask

    initial begin
        vec_t vecs [10];
        int line_f_cnt = 0;
        int hs_low_cnt = 0;
        int s_vs_cnt   = 0;
        int fall0 = -1, fall1 = -1;
        logic prev_hs;

        vecs[0] = '{1,    1,   0, 1, 1};
        vecs[1] = '{639,  639, 0, 1, 1};
        vecs[2] = '{640,  0,   0, 1, 1};
        vecs[3] = '{656,  0,   0, 1, 1};
        vecs[4] = '{657,  0,   0, 0, 1};
        vecs[5] = '{752,  0,   0, 0, 1};
        vecs[6] = '{753,  0,   0, 1, 1};
        vecs[7] = '{800,  0,   1, 1, 1};
        vecs[8] = '{801,  1,   1, 1, 1};
        vecs[9] = '{1457, 0,   0, 0, 1};

        repeat (10) @(posedge clk);
        #1;
        check_reset_state("rst_hold");

        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        #1;
        compare_all();

        phase_b = 1'b1;
        prev_hs = d_hs;
        for (int n = 0; n < 2600; n++) begin
            step();
            for (int k = 0; k < 10; k++) begin
                if (vecs[k].t == t) begin
                    check($sformatf("vec%0d_x", k), d_x, vecs[k].x);
                    check($sformatf("vec%0d_y", k), d_y, vecs[k].y);
                    check($sformatf("vec%0d_sync", k), {d_hs, d_vs}, {vecs[k].hs[0], vecs[k].vs[0]});
                end
            end
            if (t >= 801 && t <= 1600 && {d_r, d_g, d_b} == 12'hFFF) line_f_cnt++;
            if (t <= 800 && !d_hs) hs_low_cnt++;
            if (t <= 416 && s_vs) s_vs_cnt++;
            if (prev_hs && !d_hs) begin
                if (fall0 < 0) fall0 = t;
                else if (fall1 < 0) fall1 = t;
            end
            prev_hs = d_hs;
            if (t == 415) check("s_wrap_pre", {s_x, s_y}, 0);
            if (t == 416) check("s_wrap", {s_x, s_y}, 0);
            if (t == 417) check("s_wrap_post", {s_x, s_y}, {11'd1, 11'd0});
`ifdef VGA_TEST_PATTERN_EN
            if (t == 131) check("pattern_x130", {d_r, d_g, d_b}, 12'hFF0);
`endif
        end
        phase_b = 1'b0;
        check("line_f_run", line_f_cnt, 640);
        check("hs_low_width", hs_low_cnt, 96);
        check("s_vs_width", s_vs_cnt, 64);
        check("hs_first_fall", fall0, 657);
        check("hs_period", fall1 - fall0, 800);

        for (int n = 0; n < 100; n++) step();
        check("pre_reset_x", d_x, 300);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst_mid");

        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        #1;
        compare_all();
        align = 1'b1;
        for (int n = 0; n < 900; n++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
